sd_cmd_init_sequencer: RTL and testbench
========================================

Name: sd_cmd_init_sequencer

Overview:
Host-side sequencer that drives cmd_controller through the SD card identification sequence after power-up: CMD0, CMD8, CMD55/ACMD41 loop, CMD2, CMD3.
- Issues each command through the new_command/cmd_index/cmd_argument interface and waits for completion or timeout.
- Checks each response and latches the card RCA.
- Reports done or a coded error to the register block.

Parameters:
- MAX_RETRIES, 16'd1000, ACMD41 attempts allowed before giving up.
- OCR_ARG, 32'h40FF8000, ACMD41 argument (HCS plus voltage window).
- CHECK_PATTERN, 12'h1AA, CMD8 argument low bits (VHS=1, pattern AA) that must echo in the response.

Ports:
- clock  in  1  host clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to run the sequence
- cmd_done  in  1  one-cycle pulse from cmd_controller: frame sent (CMD0) or response received
- cmd_timeout  in  1  one-cycle pulse: no response within the controller timeout
- response_index  in  6  index field of the received response
- response_arg  in  32  32-bit argument field of the received response
- new_command  out  1  one-cycle command strobe to cmd_controller
- cmd_index  out  6  command index presented to cmd_controller
- cmd_argument  out  32  command argument presented to cmd_controller
- busy  out  1  sequence in progress
- done  out  1  sticky, sequence completed successfully
- error  out  1  sticky, sequence aborted
- error_code  out  3  0 none, 1 CMD8 echo mismatch, 2 timeout, 3 ACMD41 retries exhausted, 4 response index mismatch
- rca  out  16  card relative address from the CMD3 response
- retry_count  out  16  number of ACMD41 attempts in the current run

Behaviour:
- Reset:
  - All outputs 0 and the FSM returns to IDLE.
  - Reset applies at any time, including mid-sequence; the command in flight is abandoned and no further new_command is issued.
- FSM states: IDLE, S_CMD0, W_CMD0, S_CMD8, W_CMD8, S_CMD55, W_CMD55, S_ACMD41, W_ACMD41, S_CMD2, W_CMD2, S_CMD3, W_CMD3, DONE, ERR. All outputs are registered.
- S_x states:
  - Last exactly one cycle, with new_command=1.
  - cmd_index and cmd_argument are loaded on entry to S_x and held constant through W_x.
- Arguments per command:
  - CMD0: 0
  - CMD8: {20'h0, CHECK_PATTERN}
  - CMD55: 0
  - ACMD41: index 41, argument OCR_ARG
  - CMD2: 0
  - CMD3: 0
- Start handling:
  - start is honoured in IDLE, DONE and ERR. It clears done, error, error_code, rca and retry_count, and sets busy.
  - The FSM enters S_CMD0 on the edge that samples start, so new_command is high in the following cycle.
  - start while busy is ignored.
- W_x states:
  - On cmd_done, move to the next S state on the next edge. The following new_command therefore occurs 1 cycle after the cycle in which cmd_done was high.
  - On cmd_timeout, go to ERR with code 2.
  - If cmd_done and cmd_timeout are high in the same cycle, timeout wins.
- W_CMD0: response fields are ignored.
- W_CMD8:
  - response_index must equal 8, else code 4.
  - response_arg[11:0] must equal CHECK_PATTERN, else code 1.
- W_CMD55: response_index must equal 55, else code 4.
- W_ACMD41 (R3 response, no index check):
  - Each entry to S_ACMD41 increments retry_count.
  - On cmd_done with response_arg[31]=1, go to S_CMD2.
  - If response_arg[31]=0 and retry_count==MAX_RETRIES, go to ERR with code 3.
  - Otherwise loop back to S_CMD55.
- W_CMD2: R2 response, no checks.
- W_CMD3:
  - response_index must equal 3, else code 4.
  - Otherwise latch rca=response_arg[31:16] and go to DONE.
- DONE: busy=0, done=1.
- ERR: busy=0, error=1, error_code holds its value. cmd_index and cmd_argument keep the values of the failed command.
- cmd_done and cmd_timeout received in IDLE, DONE or ERR are ignored.
- busy is high from the cycle after start is sampled until DONE or ERR is entered.

Test Plan:
1. Nominal run:
   - Stimulus: reset, then start. Model returns CMD8 resp_arg=32'h000001AA, ACMD41 resp_arg=32'hC0FF8000 on the first try, CMD3 resp_arg=32'h1234_0500.
   - Required: exactly 6 new_command pulses with indices 0, 8, 55, 41, 2, 3; done=1; rca=16'h1234; retry_count=1; error=0.
2. ACMD41 busy loop:
   - Stimulus: card reports bit31=0 twice, then 1.
   - Required: index sequence 55, 41, 55, 41, 55, 41, 2; retry_count=3; done=1.
3. Retry exhaustion:
   - Stimulus: MAX_RETRIES=4, bit31 always 0.
   - Required: 4 ACMD41 commands, then error=1, error_code=3, busy=0, and no further new_command.
4. CMD8 echo mismatch and wrong index:
   - Stimulus A: resp_arg=32'h000001AB. Required: error_code=1.
   - Stimulus B: a separate run with CMD55 response_index=6'd54. Required: error_code=4.
5. Timeout and simultaneity:
   - Stimulus A: cmd_timeout during W_CMD2. Required: error_code=2; cmd_index held at 2.
   - Stimulus B: cmd_done and cmd_timeout in the same cycle during W_CMD8. Required: error_code=2.
6. Reset and restart:
   - Stimulus: reset asserted during W_ACMD41.
   - Required: next cycle all outputs 0 and state IDLE.
   - Then start from ERR after test 3. Required: error cleared, sequence restarts at CMD0.
   - Start while busy. Required: no extra new_command.

Source files
------------

// File: rtl/sd_cmd_init_sequencer.sv
// sd_cmd_init_sequencer: walks an SD card through CMD0, CMD8, CMD55/ACMD41,
// CMD2 and CMD3 using the cmd_controller strobe interface.
module sd_cmd_init_sequencer #(
  parameter logic [15:0] MAX_RETRIES   = 16'd1000,
  parameter logic [31:0] OCR_ARG       = 32'h40FF8000,
  parameter logic [11:0] CHECK_PATTERN = 12'h1AA
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        cmd_done,
  input  logic        cmd_timeout,
  input  logic [5:0]  response_index,
  input  logic [31:0] response_arg,
  output logic        new_command,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_argument,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  error_code,
  output logic [15:0] rca,
  output logic [15:0] retry_count
);

  typedef enum logic [3:0] {
    IDLE, S_CMD0, W_CMD0, S_CMD8, W_CMD8,
    S_CMD55, W_CMD55, S_ACMD41, W_ACMD41,
    S_CMD2, W_CMD2, S_CMD3, W_CMD3, DONE, ERR
  } state_t;

  state_t      state, next_state;
  logic [2:0]  fail_code;
  logic        start_ok;
  logic        is_wait;

  logic        new_command_d;
  logic [5:0]  cmd_index_d;
  logic [31:0] cmd_argument_d;
  logic        busy_d, done_d, error_d;
  logic [2:0]  error_code_d;
  logic [15:0] rca_d, retry_count_d;

  logic        unused_bits;
  assign unused_bits = ^response_arg[15:12];

  assign start_ok = start &&
    (state == IDLE || state == DONE || state == ERR);

  assign is_wait = (state == W_CMD0) || (state == W_CMD8) ||
    (state == W_CMD55) || (state == W_ACMD41) ||
    (state == W_CMD2) || (state == W_CMD3);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      new_command  <= 1'b0;
      cmd_index    <= '0;
      cmd_argument <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      error_code   <= '0;
      rca          <= '0;
      retry_count  <= '0;
    end else begin
      state        <= next_state;
      new_command  <= new_command_d;
      cmd_index    <= cmd_index_d;
      cmd_argument <= cmd_argument_d;
      busy         <= busy_d;
      done         <= done_d;
      error        <= error_d;
      error_code   <= error_code_d;
      rca          <= rca_d;
      retry_count  <= retry_count_d;
    end
  end

  always_comb begin
    next_state = state;
    fail_code  = 3'd0;
    unique case (state)
      IDLE, DONE, ERR: if (start) next_state = S_CMD0;
      S_CMD0:   next_state = W_CMD0;
      W_CMD0:   if (cmd_done) next_state = S_CMD8;
      S_CMD8:   next_state = W_CMD8;
      W_CMD8:
        if (cmd_done) begin
          if (response_index != 6'd8) begin
            next_state = ERR;
            fail_code  = 3'd4;
          end else if (response_arg[11:0] != CHECK_PATTERN) begin
            next_state = ERR;
            fail_code  = 3'd1;
          end else begin
            next_state = S_CMD55;
          end
        end
      S_CMD55:  next_state = W_CMD55;
      W_CMD55:
        if (cmd_done) begin
          if (response_index != 6'd55) begin
            next_state = ERR;
            fail_code  = 3'd4;
          end else begin
            next_state = S_ACMD41;
          end
        end
      S_ACMD41: next_state = W_ACMD41;
      W_ACMD41:
        if (cmd_done) begin
          if (response_arg[31]) begin
            next_state = S_CMD2;
          end else if (retry_count == MAX_RETRIES) begin
            next_state = ERR;
            fail_code  = 3'd3;
          end else begin
            next_state = S_CMD55;
          end
        end
      S_CMD2:   next_state = W_CMD2;
      W_CMD2:   if (cmd_done) next_state = S_CMD3;
      S_CMD3:   next_state = W_CMD3;
      W_CMD3:
        if (cmd_done) begin
          if (response_index != 6'd3) begin
            next_state = ERR;
            fail_code  = 3'd4;
          end else begin
            next_state = DONE;
          end
        end
      default:  next_state = IDLE;
    endcase
    // A timeout overrides whatever cmd_done decided in the same cycle
    if (is_wait && cmd_timeout) begin
      next_state = ERR;
      fail_code  = 3'd2;
    end
  end

  always_comb begin
    new_command_d  = 1'b0;
    cmd_index_d    = cmd_index;
    cmd_argument_d = cmd_argument;
    busy_d         = 1'b1;
    done_d         = (next_state == DONE);
    error_d        = (next_state == ERR);
    error_code_d   = error_code;
    rca_d          = rca;
    retry_count_d  = retry_count;
    if (start_ok) begin
      error_code_d  = 3'd0;
      rca_d         = 16'd0;
      retry_count_d = 16'd0;
    end
    unique case (next_state)
      IDLE, DONE, ERR: busy_d = 1'b0;
      S_CMD0: begin
        new_command_d  = 1'b1;
        cmd_index_d    = 6'd0;
        cmd_argument_d = 32'd0;
      end
      S_CMD8: begin
        new_command_d  = 1'b1;
        cmd_index_d    = 6'd8;
        cmd_argument_d = {20'h0, CHECK_PATTERN};
      end
      S_CMD55: begin
        new_command_d  = 1'b1;
        cmd_index_d    = 6'd55;
        cmd_argument_d = 32'd0;
      end
      S_ACMD41: begin
        new_command_d  = 1'b1;
        cmd_index_d    = 6'd41;
        cmd_argument_d = OCR_ARG;
        retry_count_d  = retry_count + 16'd1;
      end
      S_CMD2: begin
        new_command_d  = 1'b1;
        cmd_index_d    = 6'd2;
        cmd_argument_d = 32'd0;
      end
      S_CMD3: begin
        new_command_d  = 1'b1;
        cmd_index_d    = 6'd3;
        cmd_argument_d = 32'd0;
      end
      default: ;
    endcase
    if (next_state == ERR && state != ERR)
      error_code_d = fail_code;
    if (state == W_CMD3 && next_state == DONE)
      rca_d = response_arg[31:16];
  end

endmodule

// File: tb/tb_sd_cmd_init_sequencer.sv
// tb_sd_cmd_init_sequencer: scripted card responder with a sequence-level
// model of the identification flow.
module tb_sd_cmd_init_sequencer;

  localparam logic [15:0] MAXR = 16'd4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        cmd_done = 1'b0;
  logic        cmd_timeout = 1'b0;
  logic [5:0]  response_index = '0;
  logic [31:0] response_arg = '0;
  logic        new_command;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_argument;
  logic        busy, done, error;
  logic [2:0]  error_code;
  logic [15:0] rca, retry_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  sd_cmd_init_sequencer #(.MAX_RETRIES(MAXR)) dut (
    .clock(clock), .reset(reset), .start(start),
    .cmd_done(cmd_done), .cmd_timeout(cmd_timeout),
    .response_index(response_index), .response_arg(response_arg),
    .new_command(new_command), .cmd_index(cmd_index),
    .cmd_argument(cmd_argument), .busy(busy), .done(done),
    .error(error), .error_code(error_code), .rca(rca),
    .retry_count(retry_count)
  );

  int          sc_busy;
  logic [31:0] sc_cmd8_arg;
  logic [5:0]  sc_cmd8_idx, sc_cmd55_idx, sc_cmd3_idx;
  logic [15:0] sc_rca;
  bit          sc_to_cmd2, sc_both_cmd8, sc_start_busy, sc_reset_41;

  int          exp_q[$];
  int          got_q[$];
  logic        exp_done, exp_err;
  logic [2:0]  exp_code;
  logic [15:0] exp_rca, exp_retry;

  task automatic set_nominal();
    sc_busy       = 0;
    sc_cmd8_arg   = 32'h000001AA;
    sc_cmd8_idx   = 6'd8;
    sc_cmd55_idx  = 6'd55;
    sc_cmd3_idx   = 6'd3;
    sc_rca        = 16'h1234;
    sc_to_cmd2    = 0;
    sc_both_cmd8  = 0;
    sc_start_busy = 0;
    sc_reset_41   = 0;
  endtask

  function automatic logic [31:0] exp_arg(input logic [5:0] idx);
    if (idx == 6'd8) return 32'h000001AA;
    if (idx == 6'd41) return 32'h40FF8000;
    return 32'd0;
  endfunction

  // Expected command list and outcome from the card's scripted behaviour
  task automatic build_model();
    int tries = 0;
    bit fin = 0;
    exp_q.delete();
    exp_code = 3'd0;
    exp_rca = 16'd0;
    exp_q.push_back(0);
    exp_q.push_back(8);
    if (sc_both_cmd8) exp_code = 3'd2;
    else if (sc_cmd8_idx != 6'd8) exp_code = 3'd4;
    else if (sc_cmd8_arg[11:0] != 12'h1AA) exp_code = 3'd1;
    else begin
      while (exp_code == 0 && !fin) begin
        exp_q.push_back(55);
        if (sc_cmd55_idx != 6'd55) exp_code = 3'd4;
        else begin
          exp_q.push_back(41);
          tries++;
          if (tries > sc_busy) fin = 1;
          else if (tries == int'(MAXR)) exp_code = 3'd3;
        end
      end
      if (exp_code == 0) begin
        exp_q.push_back(2);
        if (sc_to_cmd2) exp_code = 3'd2;
        else begin
          exp_q.push_back(3);
          if (sc_cmd3_idx != 6'd3) exp_code = 3'd4;
          else exp_rca = sc_rca;
        end
      end
    end
    exp_retry = 16'(tries);
    exp_err = (exp_code != 0);
    exp_done = !exp_err;
  endtask

  task automatic run_seq(input string tag);
    int cyc = 0;
    int a41 = 0;
    int lat;
    int stray = 0;
    bit first = 1;
    bit bad;
    logic [5:0] idx;
    build_model();
    got_q.delete();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    while (cyc < 3000) begin
      if (new_command) begin
        idx = cmd_index;
        got_q.push_back(int'(idx));
        if (first) begin
          first = 0;
          checks++;
          if (error !== 1'b0 || done !== 1'b0 || error_code !== 3'd0 ||
              busy !== 1'b1 || retry_count !== 16'd0 || rca !== 16'd0) begin
            errors++;
            $display("FAIL %s start_clear: err=%b done=%b code=%0d busy=%b retry=%0d rca=%h required 0 0 0 1 0 0",
                     tag, error, done, error_code, busy, retry_count, rca);
          end
        end
        checks++;
        if (cmd_argument !== exp_arg(idx)) begin
          errors++;
          $display("FAIL %s arg cmd%0d: got %h required %h",
                   tag, idx, cmd_argument, exp_arg(idx));
        end
        if (sc_reset_41 && idx == 6'd41) begin
          @(negedge clock);
          reset = 1'b1;
          @(negedge clock);
          reset = 1'b0;
          checks++;
          if ({new_command, busy, done, error, error_code, rca, retry_count,
               cmd_index, cmd_argument} !== '0) begin
            errors++;
            $display("FAIL %s reset_outputs: nc=%b busy=%b done=%b err=%b code=%0d rca=%h retry=%0d idx=%0d arg=%h required all 0",
                     tag, new_command, busy, done, error, error_code, rca,
                     retry_count, cmd_index, cmd_argument);
          end
          cmd_done = 1'b1;
          response_arg = 32'h80000000;
          @(negedge clock);
          cmd_done = 1'b0;
          repeat (5) begin
            @(negedge clock);
            if (new_command || busy) stray++;
          end
          checks++;
          if (stray != 0) begin
            errors++;
            $display("FAIL %s idle_after_reset: %0d active cycles required 0",
                     tag, stray);
          end
          return;
        end
        lat = $urandom_range(1, 4);
        if (sc_start_busy && idx == 6'd8) lat = 2;
        for (int i = 0; i < lat; i++) begin
          @(negedge clock);
          start = (sc_start_busy && idx == 6'd8 && i == 0);
        end
        start = 1'b0;
        checks++;
        if (cmd_index !== idx || new_command !== 1'b0) begin
          errors++;
          $display("FAIL %s hold cmd%0d: idx=%0d nc=%b required idx %0d nc 0",
                   tag, idx, cmd_index, new_command, idx);
        end
        cmd_done = 1'b1;
        response_index = 6'($urandom);
        response_arg = $urandom;
        case (idx)
          6'd8: begin
            response_index = sc_cmd8_idx;
            response_arg = sc_cmd8_arg;
            cmd_timeout = sc_both_cmd8;
          end
          6'd55: response_index = sc_cmd55_idx;
          6'd41: begin
            a41++;
            response_arg[31] = (a41 > sc_busy);
          end
          6'd2: if (sc_to_cmd2) begin
            cmd_done = 1'b0;
            cmd_timeout = 1'b1;
          end
          6'd3: begin
            response_index = sc_cmd3_idx;
            response_arg[31:16] = sc_rca;
          end
          default: ;
        endcase
        @(negedge clock);
        cmd_done = 1'b0;
        cmd_timeout = 1'b0;
        cyc += lat + 1;
        if (got_q.size() < exp_q.size()) begin
          checks++;
          if (new_command !== 1'b1) begin
            errors++;
            $display("FAIL %s next_cmd_latency after cmd%0d: nc=%b required 1",
                     tag, idx, new_command);
          end
        end
      end else if (!busy) begin
        break;
      end else begin
        @(negedge clock);
        cyc++;
      end
    end
    checks++;
    if (cyc >= 3000) begin
      errors++;
      $display("FAIL %s cycle_budget: %0d cycles required < 3000", tag, cyc);
    end
    cmd_done = 1'b1;
    cmd_timeout = 1'b1;
    @(negedge clock);
    cmd_done = 1'b0;
    cmd_timeout = 1'b0;
    if (new_command) stray++;
    repeat (4) begin
      @(negedge clock);
      if (new_command) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL %s stray_cmd: %0d extra strobes required 0", tag, stray);
    end
    checks++;
    bad = (got_q.size() != exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] != exp_q[i]) bad = 1;
    if (bad) begin
      errors++;
      $display("FAIL %s cmd_seq: got %0d cmds (last %0d) required %0d cmds (last %0d)",
               tag, got_q.size(), (got_q.size() > 0) ? got_q[$] : -1,
               exp_q.size(), exp_q[$]);
    end
    checks++;
    if (done !== exp_done || error !== exp_err || error_code !== exp_code ||
        busy !== 1'b0 || rca !== exp_rca || retry_count !== exp_retry) begin
      errors++;
      $display("FAIL %s final: done=%b err=%b code=%0d busy=%b rca=%h retry=%0d required %b %b %0d 0 %h %0d",
               tag, done, error, error_code, busy, rca, retry_count,
               exp_done, exp_err, exp_code, exp_rca, exp_retry);
    end
    if (exp_err) begin
      checks++;
      if (int'(cmd_index) != exp_q[$]) begin
        errors++;
        $display("FAIL %s err_cmd_index: got %0d required %0d",
                 tag, cmd_index, exp_q[$]);
      end
    end
  endtask

  task automatic test_reset();
    int act = 0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({new_command, busy, done, error, error_code, rca, retry_count,
         cmd_index, cmd_argument} !== '0) begin
      errors++;
      $display("FAIL reset_state: nc=%b busy=%b done=%b err=%b code=%0d required all 0",
               new_command, busy, done, error, error_code);
    end
    reset = 1'b0;
    cmd_done = 1'b1;
    @(negedge clock);
    cmd_done = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (new_command || busy) act++;
    end
    checks++;
    if (act != 0) begin
      errors++;
      $display("FAIL idle_ignore_done: %0d active cycles required 0", act);
    end
  endtask

  task automatic test_nominal();
    set_nominal();
    run_seq("nominal");
  endtask

  task automatic test_acmd41_loop();
    set_nominal();
    sc_busy = 2;
    sc_rca = 16'hBEEF;
    run_seq("acmd41_loop");
  endtask

  task automatic test_retry_exhaust();
    set_nominal();
    sc_busy = 1000;
    run_seq("retry_exhaust");
  endtask

  task automatic test_cmd8_mismatch();
    set_nominal();
    sc_cmd8_arg = 32'h000001AB;
    run_seq("cmd8_echo");
  endtask

  task automatic test_cmd55_index();
    set_nominal();
    sc_cmd55_idx = 6'd54;
    run_seq("cmd55_index");
  endtask

  task automatic test_timeout();
    set_nominal();
    sc_to_cmd2 = 1;
    run_seq("timeout_cmd2");
    set_nominal();
    sc_both_cmd8 = 1;
    run_seq("done_and_timeout");
  endtask

  task automatic test_reset_mid();
    set_nominal();
    sc_busy = 3;
    sc_reset_41 = 1;
    run_seq("reset_mid");
  endtask

  task automatic test_restart_from_err();
    test_retry_exhaust();
    set_nominal();
    sc_rca = 16'h0A0B;
    run_seq("restart_from_err");
  endtask

  task automatic test_start_busy();
    set_nominal();
    sc_start_busy = 1;
    sc_busy = 1;
    run_seq("start_busy");
  endtask

  task automatic test_random();
    int fault;
    for (int n = 0; n < 20; n++) begin
      set_nominal();
      sc_busy = $urandom_range(0, 5);
      sc_rca = 16'($urandom);
      fault = $urandom_range(0, 7);
      case (fault)
        3: sc_cmd8_arg = $urandom;
        4: sc_cmd55_idx = 6'($urandom);
        5: sc_to_cmd2 = 1;
        6: sc_cmd3_idx = 6'($urandom);
        7: sc_cmd8_idx = 6'($urandom);
        default: ;
      endcase
      run_seq($sformatf("random%0d", n));
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_acmd41_loop();
    test_retry_exhaust();
    test_cmd8_mismatch();
    test_cmd55_index();
    test_timeout();
    test_reset_mid();
    test_restart_from_err();
    test_start_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
